// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NREQ requesters; latches the winner's descriptor.
// Optional per-requester occupancy counters are built when DMA_ARB_PERF_EN is defined.
module dma_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_info1,
    input  logic [32*NREQ-1:0]   req_mem_info1,
    input  logic [32*NREQ-1:0]   req_info2,
    input  logic [32*NREQ-1:0]   req_mem_info2,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 s_dma,
    output logic [2:0]           dma_op,
    output logic [31:0]          dma_info1,
    output logic [31:0]          dma_mem_info1,
    output logic [31:0]          dma_info2,
    output logic [31:0]          dma_mem_info2,
    input  logic                 f_dma,
    output logic [64*NREQ-1:0]   busy_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_last;
    logic [PW-1:0]     r_owner;
    logic [PW-1:0]     w_win;
    logic              w_found;
    logic [PW:0]       w_sum;
    logic [NREQ-1:0]   w_eff_req;
    logic [NREQ-1:0]   w_win_oh;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic [2:0]        r_op;
    logic [31:0]       r_info1;
    logic [31:0]       r_mem_info1;
    logic [31:0]       r_info2;
    logic [31:0]       r_mem_info2;

    logic [2:0]        w_op_arr       [NREQ];
    logic [31:0]       w_info1_arr    [NREQ];
    logic [31:0]       w_mem_info1_arr[NREQ];
    logic [31:0]       w_info2_arr    [NREQ];
    logic [31:0]       w_mem_info2_arr[NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_op_arr[g]        = req_op[3*g +: 3];
        assign w_info1_arr[g]     = req_info1[32*g +: 32];
        assign w_mem_info1_arr[g] = req_mem_info1[32*g +: 32];
        assign w_info2_arr[g]     = req_info2[32*g +: 32];
        assign w_mem_info2_arr[g] = req_mem_info2[32*g +: 32];
    end

    // The owner's request is still high during its done cycle; masking it prevents a re-issue.
    assign w_eff_req = req & ~r_done;

    // Walk from last+NREQ down to last+1 so the closest candidate after last is written last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            if (w_eff_req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_BUSY;
            S_BUSY:  if (f_dma) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= PW'(NREQ - 1);
            r_owner     <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_op        <= '0;
            r_info1     <= '0;
            r_mem_info1 <= '0;
            r_info2     <= '0;
            r_mem_info2 <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_win_oh;
                        r_owner     <= w_win;
                        r_op        <= w_op_arr[w_win];
                        r_info1     <= w_info1_arr[w_win];
                        r_mem_info1 <= w_mem_info1_arr[w_win];
                        r_info2     <= w_info2_arr[w_win];
                        r_mem_info2 <= w_mem_info2_arr[w_win];
                    end
                end
                S_BUSY: begin
                    if (f_dma) begin
                        r_done  <= r_grant;
                        r_last  <= r_owner;
                        r_grant <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant         = r_grant;
    assign done          = r_done;
    assign s_dma         = (r_state == S_ISSUE);
    assign dma_op        = r_op;
    assign dma_info1     = r_info1;
    assign dma_mem_info1 = r_mem_info1;
    assign dma_info2     = r_info2;
    assign dma_mem_info2 = r_mem_info2;

`ifdef DMA_ARB_PERF_EN
    logic [63:0] r_cnt [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt[g] <= '0;
            end else if (r_state != S_IDLE && r_grant[g]) begin
                r_cnt[g] <= r_cnt[g] + 64'd1;
            end
        end
        assign busy_cnt[64*g +: 64] = r_cnt[g];
    end
`else
    assign busy_cnt = '0;
`endif

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: a transfer-level reference model checked every cycle,
// a grant-order scoreboard, and literal expectations for each scenario.
module tb_dma_arbiter;

    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [3*NREQ-1:0]    req_op = '0;
    logic [32*NREQ-1:0]   req_info1 = '0;
    logic [32*NREQ-1:0]   req_mem_info1 = '0;
    logic [32*NREQ-1:0]   req_info2 = '0;
    logic [32*NREQ-1:0]   req_mem_info2 = '0;
    logic                 f_dma = 1'b0;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic                 s_dma;
    logic [2:0]           dma_op;
    logic [31:0]          dma_info1;
    logic [31:0]          dma_mem_info1;
    logic [31:0]          dma_info2;
    logic [31:0]          dma_mem_info2;
    logic [64*NREQ-1:0]   busy_cnt;

    dma_arbiter #(.NREQ(NREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_op        (req_op),
        .req_info1     (req_info1),
        .req_mem_info1 (req_mem_info1),
        .req_info2     (req_info2),
        .req_mem_info2 (req_mem_info2),
        .grant         (grant),
        .done          (done),
        .s_dma         (s_dma),
        .dma_op        (dma_op),
        .dma_info1     (dma_info1),
        .dma_mem_info1 (dma_mem_info1),
        .dma_info2     (dma_info2),
        .dma_mem_info2 (dma_mem_info2),
        .f_dma         (f_dma),
        .busy_cnt      (busy_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int tests_run = 0;
    int fails     = 0;
    bit sim_on    = 1'b1;
    logic [NREQ-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner index (-1 when nobody holds the DMA), whether this is the start cycle,
    // the rotating last-served pointer, and the latched descriptor.
    int              m_owner = -1;
    bit              m_issue = 1'b0;
    int              m_last  = NREQ - 1;
    logic [NREQ-1:0] m_done  = '0;
    logic [2:0]      m_op    = '0;
    logic [31:0]     m_w [4] = '{default: '0};
    longint unsigned m_cnt [NREQ] = '{default: 0};

    task automatic model_step();
        logic [NREQ-1:0] eff;
        bit found;
        int c;
        if (rst) begin
            m_owner = -1;
            m_issue = 1'b0;
            m_last  = NREQ - 1;
            m_done  = '0;
            m_op    = '0;
            for (int i = 0; i < 4; i++) m_w[i] = '0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else begin
            if (m_owner >= 0) m_cnt[m_owner]++;
            eff    = req & ~m_done;
            m_done = '0;
            if (m_owner < 0) begin
                if (eff != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NREQ; k++) begin
                        c = (m_last + k) % NREQ;
                        if (!found && eff[c]) begin
                            found   = 1'b1;
                            m_owner = c;
                        end
                    end
                    m_issue = 1'b1;
                    m_op    = req_op[3*m_owner +: 3];
                    m_w[0]  = req_info1[32*m_owner +: 32];
                    m_w[1]  = req_mem_info1[32*m_owner +: 32];
                    m_w[2]  = req_info2[32*m_owner +: 32];
                    m_w[3]  = req_mem_info2[32*m_owner +: 32];
                end
            end else if (m_issue) begin
                m_issue = 1'b0;
            end else if (f_dma) begin
                m_done[m_owner] = 1'b1;
                m_last          = m_owner;
                m_owner         = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] eg;
        longint unsigned ec;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("m_grant", grant, eg);
        check("m_s_dma", s_dma, m_issue);
        check("m_done", done, m_done);
        check("m_dma_op", dma_op, m_op);
        check("m_info1", dma_info1, m_w[0]);
        check("m_mem_info1", dma_mem_info1, m_w[1]);
        check("m_info2", dma_info2, m_w[2]);
        check("m_mem_info2", dma_mem_info2, m_w[3]);
        for (int i = 0; i < NREQ; i++) begin
`ifdef DMA_ARB_PERF_EN
            ec = m_cnt[i];
`else
            ec = 0;
`endif
            check($sformatf("m_busy_cnt%0d", i), busy_cnt[64*i +: 64], ec);
        end
        if (s_dma === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fails++;
                $display("FAIL sb_unexpected_start: got grant 0x%0h, expected no start", grant);
            end else begin
                check("sb_grant_order", grant, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (sim_on) compare_all();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_desc(input int i, input logic [2:0] op, input logic [31:0] base);
        req_op[3*i +: 3]         = op;
        req_info1[32*i +: 32]    = base;
        req_mem_info1[32*i +: 32] = base + 32'd1;
        req_info2[32*i +: 32]    = base + 32'd2;
        req_mem_info2[32*i +: 32] = base + 32'd3;
    endtask

    task automatic reset_dut();
        req = '0;
        f_dma = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the start pulse, finishes the transfer 'gap' cycles later, ends in the done cycle.
    task automatic xfer(input int exp_idx, input int gap, input string tag);
        int n;
        n = 0;
        while (s_dma !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (s_dma !== 1'b1) begin
            tests_run++;
            fails++;
            $display("FAIL %s_start_timeout: got no s_dma, expected one within 20 cycles", tag);
            return;
        end
        check({tag, "_grant"}, grant, 64'(1) << exp_idx);
        repeat (gap) @(negedge clk);
        f_dma = 1'b1;
        @(negedge clk);
        f_dma = 1'b0;
        check({tag, "_done"}, done, 64'(1) << exp_idx);
        check({tag, "_grant_clr"}, grant, 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_s_dma", s_dma, 0);
        check("rst_dma_op", dma_op, 0);
        check("rst_info1", dma_info1, 0);
        check("rst_busy_cnt", busy_cnt, 0);

        // Single requester, descriptor changes after the win must not leak through.
        set_desc(0, 3'd1, 32'h10);
        exp_q.push_back(3'b001);
        req = 3'b001;
        @(negedge clk);
        check("t1_s_dma", s_dma, 1);
        check("t1_grant", grant, 3'b001);
        check("t1_dma_op", dma_op, 1);
        check("t1_info1", dma_info1, 32'h10);
        req_info1[31:0] = 32'hdead_beef;
        req_op[2:0] = 3'd6;
        repeat (5) @(negedge clk);
        check("t1_busy_hold_info1", dma_info1, 32'h10);
        check("t1_busy_no_done", done, 0);
        f_dma = 1'b1;
        @(negedge clk);
        f_dma = 1'b0;
        req = '0;
        check("t1_done", done, 3'b001);
        @(negedge clk);
        check("t1_done_one_cycle", done, 0);
        check("t1_no_restart", s_dma, 0);

        // Round robin with everyone requesting, then requesters 0 and 2 only.
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_desc(i, 3'(i + 2), 32'h100 * (i + 1));
        req = 3'b111;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        xfer(0, 2, "rr_a");
        xfer(1, 3, "rr_b");
        xfer(2, 1, "rr_c");
        xfer(0, 2, "rr_d");
        xfer(1, 2, "rr_e");
        req = 3'b101;
        exp_q.push_back(3'b100); exp_q.push_back(3'b001);
        exp_q.push_back(3'b100); exp_q.push_back(3'b001);
        xfer(2, 2, "rr_f");
        xfer(0, 1, "rr_g");
        xfer(2, 1, "rr_h");
        xfer(0, 1, "rr_i");
        req = '0;
        @(negedge clk);
        check("rr_idle_after", s_dma, 0);

        // Level request held through done must not be issued twice.
        reset_dut();
        req = 3'b010;
        exp_q.push_back(3'b010);
        xfer(1, 2, "lvl");
        @(negedge clk);
        req = '0;
        check("lvl_no_reissue", s_dma, 0);
        check("lvl_grant_idle", grant, 0);
        repeat (3) @(negedge clk);

        // Finish pulses outside BUSY are ignored.
        reset_dut();
        f_dma = 1'b1;
        @(negedge clk);
        f_dma = 1'b0;
        check("spur_idle_done", done, 0);
        check("spur_idle_grant", grant, 0);
        req = 3'b001;
        exp_q.push_back(3'b001);
        @(negedge clk);
        check("spur_issue_s_dma", s_dma, 1);
        f_dma = 1'b1;
        @(negedge clk);
        f_dma = 1'b0;
        check("spur_issue_done", done, 0);
        check("spur_issue_grant", grant, 3'b001);
        @(negedge clk);
        check("spur_busy_done", done, 0);
        f_dma = 1'b1;
        @(negedge clk);
        f_dma = 1'b0;
        req = '0;
        check("spur_real_done", done, 3'b001);

        // Reset in the middle of BUSY.
        reset_dut();
        req = 3'b001;
        exp_q.push_back(3'b001);
        repeat (2) @(negedge clk);
        check("mid_busy_grant", grant, 3'b001);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_dma_op", dma_op, 0);
        check("mid_rst_info2", dma_info2, 0);
        req = 3'b110;
        exp_q.push_back(3'b010);
        @(negedge clk);
        check("mid_rst_no_done", done, 0);
        xfer(1, 2, "mid_next");
        req = '0;

        // Occupancy counters.
        reset_dut();
        req = 3'b100;
        exp_q.push_back(3'b100);
        xfer(2, 4, "perf");
        req = '0;
        @(negedge clk);
`ifdef DMA_ARB_PERF_EN
        check("perf_cnt2", busy_cnt[128 +: 64], 64'd5);
`else
        check("perf_cnt2", busy_cnt[128 +: 64], 64'd0);
`endif
        check("perf_cnt0", busy_cnt[0 +: 64], 64'd0);
        check("perf_cnt1", busy_cnt[64 +: 64], 64'd0);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        sim_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1);
    end

endmodule
